branch_target_predictor: RTL and testbench

//  Parametrised IF-stage branch predictor for the 5-stage pipelined MIPS core.
//  It holds a direct-mapped BTB with 2-bit saturating direction counters, and gives a

---
 rtl/mips_bp_pkg.sv | 23 ++
 rtl/bp_table.sv | 62 ++++++
 rtl/branch_target_predictor.sv | 110 +++++++++++
 tb/tb_branch_target_predictor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_bp_pkg.sv
// Shared constants and counter helper for the IF-stage branch predictor.
package mips_bp_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [1:0] CNT_WEAK_NT  = 2'b01;
  localparam logic [1:0] CNT_WEAK_T   = 2'b10;
  localparam logic [1:0] CNT_STRONG_T = 2'b11;

  // Clamped up/down step; counters up to 8 bits wide, cnt_max is the ceiling
  function automatic logic [7:0] sat_inc_dec(input logic [7:0] cnt, input logic up,
                                             input logic [7:0] cnt_max);
    logic [7:0] res;
    res = cnt;
    if (up) begin
      if (cnt != cnt_max) res = cnt + 8'd1;
    end else if (cnt != 8'd0) begin
      res = cnt - 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped BTB storage: lookup read port, update read port, one write port.
module bp_table #(
  parameter int unsigned   ENTRIES = 16,
  parameter int unsigned   IDX_W   = 4,
  parameter int unsigned   TAG_W   = 8,
  parameter int unsigned   CNT_W   = 2,
  parameter int unsigned   PC_W    = 32,
  parameter logic [CNT_W-1:0] CNT_RST = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_lk_idx,
  output logic             o_lk_valid,
  output logic [TAG_W-1:0] o_lk_tag,
  output logic [PC_W-1:0]  o_lk_target,
  output logic [CNT_W-1:0] o_lk_cnt,
  input  logic [IDX_W-1:0] i_up_idx,
  output logic             o_up_valid,
  output logic [TAG_W-1:0] o_up_tag,
  output logic [CNT_W-1:0] o_up_cnt,
  input  logic             i_wr_en,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic             i_wr_target_en,
  input  logic [PC_W-1:0]  i_wr_target,
  input  logic [CNT_W-1:0] i_wr_cnt
);

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [PC_W-1:0]  r_target [ENTRIES];
  logic [CNT_W-1:0] r_cnt    [ENTRIES];

  assign o_lk_valid  = r_valid[i_lk_idx];
  assign o_lk_tag    = r_tag[i_lk_idx];
  assign o_lk_target = r_target[i_lk_idx];
  assign o_lk_cnt    = r_cnt[i_lk_idx];
  assign o_up_valid  = r_valid[i_up_idx];
  assign o_up_tag    = r_tag[i_up_idx];
  assign o_up_cnt    = r_cnt[i_up_idx];

  // Valid and counter state clear asynchronously; a reset wipes any write in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= CNT_RST;
      end
    end else if (i_wr_en) begin
      r_valid[i_up_idx] <= 1'b1;
      r_cnt[i_up_idx]   <= i_wr_cnt;
    end
  end

  // Tag/target are qualified by valid, so they need no reset
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_up_idx] <= i_wr_tag;
      if (i_wr_target_en) r_target[i_up_idx] <= i_wr_target;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// IF-stage BTB predictor with EX-stage resolution, redirect and saturating statistics.
module branch_target_predictor
  import mips_bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned STAT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       if_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic              upd_uncond,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              ex_pred_taken,
  input  logic [31:0]       ex_pred_target,
  output logic              mispredict,
  output logic [31:0]       redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  // 2-bit encodings widened: MSB kept, low bit replicated
  localparam logic [CNT_W-1:0] L_WEAK_NT  = {CNT_WEAK_NT[1],  {(CNT_W-1){CNT_WEAK_NT[0]}}};
  localparam logic [CNT_W-1:0] L_WEAK_T   = {CNT_WEAK_T[1],   {(CNT_W-1){CNT_WEAK_T[0]}}};
  localparam logic [CNT_W-1:0] L_STRONG_T = {CNT_STRONG_T[1], {(CNT_W-1){CNT_STRONG_T[0]}}};

  logic [IDX_W-1:0]  w_lk_idx, w_up_idx;
  logic [TAG_W-1:0]  w_lk_tag_in, w_up_tag_in, w_lk_tag, w_up_tag;
  logic              w_lk_valid, w_up_valid, w_lk_hit, w_up_hit;
  logic [PC_W-1:0]   w_lk_target;
  logic [CNT_W-1:0]  w_lk_cnt, w_up_cnt, w_wr_cnt;
  logic              w_wr_en, w_wr_target_en;
  logic              w_unused_pc;
  logic [STAT_W-1:0] r_stat_branches, r_stat_mispred;

  assign w_lk_idx    = if_pc[IDX_W+1:2];
  assign w_lk_tag_in = if_pc[IDX_W+2 +: TAG_W];
  assign w_up_idx    = upd_pc[IDX_W+1:2];
  assign w_up_tag_in = upd_pc[IDX_W+2 +: TAG_W];
  assign w_unused_pc = ^{if_pc, upd_pc};

  bp_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W),
    .CNT_W   (CNT_W),
    .PC_W    (PC_W),
    .CNT_RST (L_WEAK_NT)
  ) u_table (
    .clk            (clk),
    .rst_n          (reset),
    .i_lk_idx       (w_lk_idx),
    .o_lk_valid     (w_lk_valid),
    .o_lk_tag       (w_lk_tag),
    .o_lk_target    (w_lk_target),
    .o_lk_cnt       (w_lk_cnt),
    .i_up_idx       (w_up_idx),
    .o_up_valid     (w_up_valid),
    .o_up_tag       (w_up_tag),
    .o_up_cnt       (w_up_cnt),
    .i_wr_en        (w_wr_en),
    .i_wr_tag       (w_up_tag_in),
    .i_wr_target_en (w_wr_target_en),
    .i_wr_target    (upd_target),
    .i_wr_cnt       (w_wr_cnt)
  );

  assign w_lk_hit    = w_lk_valid && (w_lk_tag == w_lk_tag_in);
  assign pred_taken  = w_lk_hit && w_lk_cnt[CNT_W-1];
  assign pred_target = pred_taken ? w_lk_target : (if_pc + 32'd4);

  assign w_up_hit    = w_up_valid && (w_up_tag == w_up_tag_in);
  assign mispredict  = upd_valid && ((upd_taken != ex_pred_taken) ||
                                     (upd_taken && (upd_target != ex_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : (upd_pc + 32'd4);

  // Not-taken misses never allocate; everything else writes the indexed entry
  always_comb begin
    w_wr_en        = upd_valid && (w_up_hit || upd_taken);
    w_wr_target_en = upd_taken || upd_uncond;
    w_wr_cnt       = L_WEAK_T;
    if (upd_uncond) begin
      w_wr_cnt = L_STRONG_T;
    end else if (w_up_hit) begin
      w_wr_cnt = CNT_W'(sat_inc_dec(8'(w_up_cnt), upd_taken, 8'(L_STRONG_T)));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_branches <= '0;
      r_stat_mispred  <= '0;
    end else begin
      if (upd_valid && (r_stat_branches != '1)) r_stat_branches <= r_stat_branches + STAT_W'(1);
      if (mispredict && (r_stat_mispred != '1)) r_stat_mispred  <= r_stat_mispred + STAT_W'(1);
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_mispred  = r_stat_mispred;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed scenario bench for branch_target_predictor (16 entries, 4-bit stats).
module tb_branch_target_predictor;

  localparam int unsigned STAT_W = 4;

  logic              clk;
  logic              reset;
  logic [31:0]       if_pc;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic              upd_valid, upd_uncond, upd_taken, ex_pred_taken;
  logic [31:0]       upd_pc, upd_target, ex_pred_target;
  logic              mispredict;
  logic [31:0]       redirect_pc;
  logic [STAT_W-1:0] stat_branches, stat_mispred;

  int checks;
  int errors;
  int exp_br;
  int exp_mp;

  branch_target_predictor #(
    .ENTRIES (16),
    .TAG_W   (8),
    .CNT_W   (2),
    .STAT_W  (STAT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_uncond     (upd_uncond),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic set_upd(input logic v, input logic unc, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ept, input logic [31:0] eptgt);
    upd_valid = v; upd_uncond = unc; upd_pc = pc; upd_taken = tk;
    upd_target = tgt; ex_pred_taken = ept; ex_pred_target = eptgt;
  endtask

  task automatic bump(input bit mp);
    if (exp_br < 15) exp_br++;
    if (mp && exp_mp < 15) exp_mp++;
  endtask

  // Commit the driven update on the next edge, then drop upd_valid
  task automatic commit(input bit mp);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    bump(mp);
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_upd(1, 0, 32'h40, 1, 32'h80, 0, 32'h44);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL rst_alloc_mp got %b exp 1", mispredict); end
    checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL rst_alloc_redirect got %h exp 00000080", redirect_pc); end
    commit(1);
    if_pc = 32'h40; #1;
    checks++; if (pred_target !== 32'h80) begin errors++; $display("FAIL rst_pre_target got %h exp 00000080", pred_target); end
    checks++; if (stat_branches !== 4'd1) begin errors++; $display("FAIL rst_pre_stat got %0d exp 1", stat_branches); end
    #1 reset = 1'b0; #1;
    exp_br = 0; exp_mp = 0;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred_taken got %b exp 0", pred_taken); end
    checks++; if (pred_target !== 32'h44) begin errors++; $display("FAIL rst_pred_target got %h exp 00000044", pred_target); end
    checks++; if (stat_branches !== 4'd0 || stat_mispred !== 4'd0) begin errors++; $display("FAIL rst_stats got %0d/%0d exp 0/0", stat_branches, stat_mispred); end
    @(negedge clk); reset = 1'b1;
    set_upd(0, 0, 32'h40, 1, 32'h80, 0, 32'h0);
    #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL rst_no_valid_mp got %b exp 0", mispredict); end
    checks++; if (pred_target !== 32'h44) begin errors++; $display("FAIL rst_post_target got %h exp 00000044", pred_target); end
  endtask

  task automatic test_training();
    @(negedge clk);
    set_upd(1, 0, 32'h100, 1, 32'hF0, 0, 32'h104);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL train1_mp got %b exp 1", mispredict); end
    checks++; if (redirect_pc !== 32'hF0) begin errors++; $display("FAIL train1_redirect got %h exp 000000f0", redirect_pc); end
    commit(1);
    if_pc = 32'h100; #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'hF0) begin errors++; $display("FAIL train1_lookup got %b/%h exp 1/000000f0", pred_taken, pred_target); end
    @(negedge clk);
    set_upd(1, 0, 32'h100, 1, 32'hF0, 1, 32'hF0);
    #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL train2_mp got %b exp 0", mispredict); end
    commit(0);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'hF0) begin errors++; $display("FAIL train2_lookup got %b/%h exp 1/000000f0", pred_taken, pred_target); end
  endtask

  task automatic test_hysteresis();
    @(negedge clk);
    set_upd(1, 0, 32'h100, 0, 32'hF0, 1, 32'hF0);
    #1;
    checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h104) begin errors++; $display("FAIL hyst1_resolve got %b/%h exp 1/00000104", mispredict, redirect_pc); end
    commit(1);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'hF0) begin errors++; $display("FAIL hyst1_lookup got %b/%h exp 1/000000f0", pred_taken, pred_target); end
    @(negedge clk);
    set_upd(1, 0, 32'h100, 0, 32'hF0, 1, 32'hF0);
    commit(1);
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin errors++; $display("FAIL hyst2_lookup got %b/%h exp 0/00000104", pred_taken, pred_target); end
    checks++; if (stat_branches !== 4'(exp_br) || stat_mispred !== 4'(exp_mp)) begin errors++; $display("FAIL hyst_stats got %0d/%0d exp %0d/%0d", stat_branches, stat_mispred, exp_br, exp_mp); end
  endtask

  task automatic test_aliasing();
    @(negedge clk);
    set_upd(1, 0, 32'h100, 1, 32'hF0, 0, 32'h104);
    commit(1);
    if_pc = 32'h100; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alias_retrain got %b exp 1", pred_taken); end
    @(negedge clk);
    set_upd(1, 0, 32'h140, 1, 32'h180, 0, 32'h144);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL alias_mp got %b exp 1", mispredict); end
    commit(1);
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin errors++; $display("FAIL alias_evicted got %b/%h exp 0/00000104", pred_taken, pred_target); end
    @(negedge clk);
    set_upd(1, 0, 32'h180, 0, 32'h0, 0, 32'h184);
    #1;
    checks++; if (mispredict !== 1'b0 || redirect_pc !== 32'h184) begin errors++; $display("FAIL nt_miss_resolve got %b/%h exp 0/00000184", mispredict, redirect_pc); end
    commit(0);
    if_pc = 32'h140; #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h180) begin errors++; $display("FAIL nt_miss_noalloc got %b/%h exp 1/00000180", pred_taken, pred_target); end
  endtask

  task automatic test_jr_target();
    @(negedge clk);
    set_upd(1, 1, 32'h200, 1, 32'h300, 0, 32'h204);
    commit(1);
    if_pc = 32'h200; #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin errors++; $display("FAIL jr1_lookup got %b/%h exp 1/00000300", pred_taken, pred_target); end
    @(negedge clk);
    set_upd(1, 1, 32'h200, 1, 32'h380, 1, 32'h300);
    #1;
    checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h380) begin errors++; $display("FAIL jr2_resolve got %b/%h exp 1/00000380", mispredict, redirect_pc); end
    commit(1);
    checks++; if (pred_target !== 32'h380) begin errors++; $display("FAIL jr2_lookup got %h exp 00000380", pred_target); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    if_pc = 32'h200;
    set_upd(1, 1, 32'h200, 1, 32'h3C0, 1, 32'h380);
    #1;
    checks++; if (pred_target !== 32'h380) begin errors++; $display("FAIL hazard_old got %h exp 00000380", pred_target); end
    commit(1);
    checks++; if (pred_target !== 32'h3C0) begin errors++; $display("FAIL hazard_new got %h exp 000003c0", pred_target); end
    checks++; if (stat_branches !== 4'(exp_br) || stat_mispred !== 4'(exp_mp)) begin errors++; $display("FAIL pre_sat_stats got %0d/%0d exp %0d/%0d", stat_branches, stat_mispred, exp_br, exp_mp); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      set_upd(1, 0, 32'h500, 0, 32'h0, 1, 32'h0);
      commit(1);
    end
    checks++; if (stat_branches !== 4'hF || stat_mispred !== 4'hF) begin errors++; $display("FAIL sat_stats got %0d/%0d exp 15/15", stat_branches, stat_mispred); end
    @(negedge clk);
    set_upd(1, 0, 32'h500, 0, 32'h0, 1, 32'h0);
    commit(1);
    checks++; if (stat_branches !== 4'hF || stat_mispred !== 4'hF) begin errors++; $display("FAIL sat_hold got %0d/%0d exp 15/15", stat_branches, stat_mispred); end
    if_pc = 32'h500; #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h504) begin errors++; $display("FAIL sat_noalloc got %b/%h exp 0/00000504", pred_taken, pred_target); end
  endtask

  initial begin
    checks = 0; errors = 0; exp_br = 0; exp_mp = 0;
    reset = 1'b0; if_pc = 32'h0;
    set_upd(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_training();
    test_hysteresis();
    test_aliasing();
    test_jr_target();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
